// File: rtl/rs_station.sv
// rs_station: reservation station in front of the execute ALU.
// Holds dispatched instructions until both source operands are known,
// snoops the ALU and load/store-buffer result broadcasts to fill in
// pending operands, and issues the lowest-index ready entry each cycle
// as a registered bundle. A synchronous clear flushes everything.
module rs_station #(
    parameter int ENTRY_NUM = 16,
    parameter int DATA_W    = 32,
    parameter int OPNUM_W   = 6,
    parameter int ROB_ID_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                dispatch_valid,
    input  logic [OPNUM_W-1:0]  dispatch_opnum,
    input  logic                dispatch_q1_pending,
    input  logic                dispatch_q2_pending,
    input  logic [ROB_ID_W-1:0] dispatch_q1,
    input  logic [ROB_ID_W-1:0] dispatch_q2,
    input  logic [DATA_W-1:0]   dispatch_v1,
    input  logic [DATA_W-1:0]   dispatch_v2,
    input  logic [DATA_W-1:0]   dispatch_imm,
    input  logic [DATA_W-1:0]   dispatch_pc,
    input  logic [ROB_ID_W-1:0] dispatch_rob_id,
    output logic                full,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                lsb_valid,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_data,
    output logic [OPNUM_W-1:0]  opnum_to_ex,
    output logic [DATA_W-1:0]   v1_to_ex,
    output logic [DATA_W-1:0]   v2_to_ex,
    output logic [DATA_W-1:0]   imm_to_ex,
    output logic [DATA_W-1:0]   pc_to_ex,
    output logic [ROB_ID_W-1:0] rob_id_to_ex
);

    localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    // Lowest set bit of vec; result is {found, index}.
    function automatic logic [IDX_W:0] first_set(input logic [ENTRY_NUM-1:0] vec);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, IDX_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Entry storage
    logic [ENTRY_NUM-1:0] busy_q, busy_d;
    logic [ENTRY_NUM-1:0] q1p_q, q1p_d;
    logic [ENTRY_NUM-1:0] q2p_q, q2p_d;
    logic [OPNUM_W-1:0]   op_q  [ENTRY_NUM];
    logic [OPNUM_W-1:0]   op_d  [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  q1_q  [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  q1_d  [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  q2_q  [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  q2_d  [ENTRY_NUM];
    logic [DATA_W-1:0]    v1_q  [ENTRY_NUM];
    logic [DATA_W-1:0]    v1_d  [ENTRY_NUM];
    logic [DATA_W-1:0]    v2_q  [ENTRY_NUM];
    logic [DATA_W-1:0]    v2_d  [ENTRY_NUM];
    logic [DATA_W-1:0]    imm_q [ENTRY_NUM];
    logic [DATA_W-1:0]    imm_d [ENTRY_NUM];
    logic [DATA_W-1:0]    pc_q  [ENTRY_NUM];
    logic [DATA_W-1:0]    pc_d  [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  rob_q [ENTRY_NUM];
    logic [ROB_ID_W-1:0]  rob_d [ENTRY_NUM];

    // Issue bundle registers
    logic [OPNUM_W-1:0]  ex_op_q,  ex_op_d;
    logic [DATA_W-1:0]   ex_v1_q,  ex_v1_d;
    logic [DATA_W-1:0]   ex_v2_q,  ex_v2_d;
    logic [DATA_W-1:0]   ex_imm_q, ex_imm_d;
    logic [DATA_W-1:0]   ex_pc_q,  ex_pc_d;
    logic [ROB_ID_W-1:0] ex_rob_q, ex_rob_d;

    logic [ENTRY_NUM-1:0] ready_s;
    logic [IDX_W:0]       issue_sel_s;
    logic [IDX_W:0]       free_sel_s;
    logic                 issue_valid_s;
    logic [IDX_W-1:0]     issue_idx_s;
    logic                 dispatch_fire_s;
    logic [IDX_W-1:0]     free_idx_s;

    assign full            = &busy_q;
    assign ready_s         = busy_q & ~q1p_q & ~q2p_q;
    assign issue_sel_s     = first_set(ready_s);
    assign free_sel_s      = first_set(~busy_q);
    assign issue_valid_s   = issue_sel_s[IDX_W];
    assign issue_idx_s     = issue_sel_s[IDX_W-1:0];
    // Free slots come from current state, so an issuing entry is not reused this cycle.
    assign dispatch_fire_s = dispatch_valid & ~full & ~clear & free_sel_s[IDX_W];
    assign free_idx_s      = free_sel_s[IDX_W-1:0];

    // Entry next state: wakeup, issue release, dispatch with bypass, then clear.
    always_comb begin
        busy_d = busy_q;
        q1p_d  = q1p_q;
        q2p_d  = q2p_q;
        op_d   = op_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        rob_d  = rob_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            // Operand 1 wakeup, ALU port has priority
            if (busy_q[i] && q1p_q[i] && alu_valid && (alu_rob_id == q1_q[i])) begin
                v1_d[i]  = alu_data;
                q1p_d[i] = 1'b0;
            end else if (busy_q[i] && q1p_q[i] && lsb_valid && (lsb_rob_id == q1_q[i])) begin
                v1_d[i]  = lsb_data;
                q1p_d[i] = 1'b0;
            end else begin
                v1_d[i]  = v1_q[i];
            end
            // Operand 2 wakeup, ALU port has priority
            if (busy_q[i] && q2p_q[i] && alu_valid && (alu_rob_id == q2_q[i])) begin
                v2_d[i]  = alu_data;
                q2p_d[i] = 1'b0;
            end else if (busy_q[i] && q2p_q[i] && lsb_valid && (lsb_rob_id == q2_q[i])) begin
                v2_d[i]  = lsb_data;
                q2p_d[i] = 1'b0;
            end else begin
                v2_d[i]  = v2_q[i];
            end
            if (issue_valid_s && (issue_idx_s == IDX_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_d[i];
            end
            if (dispatch_fire_s && (free_idx_s == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                op_d[i]   = dispatch_opnum;
                q1_d[i]   = dispatch_q1;
                q2_d[i]   = dispatch_q2;
                imm_d[i]  = dispatch_imm;
                pc_d[i]   = dispatch_pc;
                rob_d[i]  = dispatch_rob_id;
                // Same-cycle broadcast bypass for operand 1
                if (dispatch_q1_pending && alu_valid && (alu_rob_id == dispatch_q1)) begin
                    q1p_d[i] = 1'b0;
                    v1_d[i]  = alu_data;
                end else if (dispatch_q1_pending && lsb_valid && (lsb_rob_id == dispatch_q1)) begin
                    q1p_d[i] = 1'b0;
                    v1_d[i]  = lsb_data;
                end else begin
                    q1p_d[i] = dispatch_q1_pending;
                    v1_d[i]  = dispatch_v1;
                end
                // Same-cycle broadcast bypass for operand 2
                if (dispatch_q2_pending && alu_valid && (alu_rob_id == dispatch_q2)) begin
                    q2p_d[i] = 1'b0;
                    v2_d[i]  = alu_data;
                end else if (dispatch_q2_pending && lsb_valid && (lsb_rob_id == dispatch_q2)) begin
                    q2p_d[i] = 1'b0;
                    v2_d[i]  = lsb_data;
                end else begin
                    q2p_d[i] = dispatch_q2_pending;
                    v2_d[i]  = dispatch_v2;
                end
            end else begin
                op_d[i] = op_d[i];
            end
        end
        if (clear) begin
            busy_d = {ENTRY_NUM{1'b0}};
        end else begin
            busy_d = busy_d;
        end
    end

    // Issue bundle next state: selected entry, or NULL/0 when idle or flushing.
    always_comb begin
        ex_op_d  = {OPNUM_W{1'b0}};
        ex_v1_d  = {DATA_W{1'b0}};
        ex_v2_d  = {DATA_W{1'b0}};
        ex_imm_d = {DATA_W{1'b0}};
        ex_pc_d  = {DATA_W{1'b0}};
        ex_rob_d = {ROB_ID_W{1'b0}};
        if (!clear && issue_valid_s) begin
            ex_op_d  = op_q[issue_idx_s];
            ex_v1_d  = v1_q[issue_idx_s];
            ex_v2_d  = v2_q[issue_idx_s];
            ex_imm_d = imm_q[issue_idx_s];
            ex_pc_d  = pc_q[issue_idx_s];
            ex_rob_d = rob_q[issue_idx_s];
        end else begin
            ex_op_d  = {OPNUM_W{1'b0}};
        end
    end

    // State and issue registers; async reset empties the station.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= {ENTRY_NUM{1'b0}};
            q1p_q    <= {ENTRY_NUM{1'b0}};
            q2p_q    <= {ENTRY_NUM{1'b0}};
            for (int i = 0; i < ENTRY_NUM; i++) begin
                op_q[i]  <= {OPNUM_W{1'b0}};
                q1_q[i]  <= {ROB_ID_W{1'b0}};
                q2_q[i]  <= {ROB_ID_W{1'b0}};
                v1_q[i]  <= {DATA_W{1'b0}};
                v2_q[i]  <= {DATA_W{1'b0}};
                imm_q[i] <= {DATA_W{1'b0}};
                pc_q[i]  <= {DATA_W{1'b0}};
                rob_q[i] <= {ROB_ID_W{1'b0}};
            end
            ex_op_q  <= {OPNUM_W{1'b0}};
            ex_v1_q  <= {DATA_W{1'b0}};
            ex_v2_q  <= {DATA_W{1'b0}};
            ex_imm_q <= {DATA_W{1'b0}};
            ex_pc_q  <= {DATA_W{1'b0}};
            ex_rob_q <= {ROB_ID_W{1'b0}};
        end else begin
            busy_q   <= busy_d;
            q1p_q    <= q1p_d;
            q2p_q    <= q2p_d;
            op_q     <= op_d;
            q1_q     <= q1_d;
            q2_q     <= q2_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            rob_q    <= rob_d;
            ex_op_q  <= ex_op_d;
            ex_v1_q  <= ex_v1_d;
            ex_v2_q  <= ex_v2_d;
            ex_imm_q <= ex_imm_d;
            ex_pc_q  <= ex_pc_d;
            ex_rob_q <= ex_rob_d;
        end
    end

    assign opnum_to_ex  = ex_op_q;
    assign v1_to_ex     = ex_v1_q;
    assign v2_to_ex     = ex_v2_q;
    assign imm_to_ex    = ex_imm_q;
    assign pc_to_ex     = ex_pc_q;
    assign rob_id_to_ex = ex_rob_q;

endmodule

// File: tb/tb_rs_station.sv
// Testbench for rs_station: directed scenarios plus a randomized run
// checked against a slot-level behavioural model.
module tb_rs_station;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        dispatch_valid;
    logic [5:0]  dispatch_opnum;
    logic        dispatch_q1_pending, dispatch_q2_pending;
    logic [3:0]  dispatch_q1, dispatch_q2;
    logic [31:0] dispatch_v1, dispatch_v2, dispatch_imm, dispatch_pc;
    logic [3:0]  dispatch_rob_id;
    logic        full;
    logic        alu_valid, lsb_valid;
    logic [3:0]  alu_rob_id, lsb_rob_id;
    logic [31:0] alu_data, lsb_data;
    logic [5:0]  opnum_to_ex;
    logic [31:0] v1_to_ex, v2_to_ex, imm_to_ex, pc_to_ex;
    logic [3:0]  rob_id_to_ex;

    int checks = 0;
    int errors = 0;

    rs_station dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .dispatch_valid(dispatch_valid), .dispatch_opnum(dispatch_opnum),
        .dispatch_q1_pending(dispatch_q1_pending), .dispatch_q2_pending(dispatch_q2_pending),
        .dispatch_q1(dispatch_q1), .dispatch_q2(dispatch_q2),
        .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2),
        .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
        .dispatch_rob_id(dispatch_rob_id), .full(full),
        .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_data(alu_data),
        .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_data(lsb_data),
        .opnum_to_ex(opnum_to_ex), .v1_to_ex(v1_to_ex), .v2_to_ex(v2_to_ex),
        .imm_to_ex(imm_to_ex), .pc_to_ex(pc_to_ex), .rob_id_to_ex(rob_id_to_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit        p1, p2;
        bit [3:0]  t1, t2;
        bit [31:0] v1, v2, imm, pc;
        bit [3:0]  rob;
    } ent_t;

    ent_t      m [16];
    bit [5:0]  e_op;
    bit [31:0] e_v1, e_v2, e_imm, e_pc;
    bit [3:0]  e_rob;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        e_op = 6'd0; e_v1 = 32'd0; e_v2 = 32'd0; e_imm = 32'd0; e_pc = 32'd0; e_rob = 4'd0;
    endtask

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) n++;
        return n == 16;
    endfunction

    // {still_pending, value} of one operand after looking at this cycle's broadcasts
    function automatic bit [32:0] snoop(input bit pend, input bit [3:0] tag, input bit [31:0] val);
        if (!pend) return {1'b0, val};
        if (alu_valid && alu_rob_id == tag) return {1'b0, alu_data};
        if (lsb_valid && lsb_rob_id == tag) return {1'b0, lsb_data};
        return {1'b1, val};
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        ent_t nx [16];
        int iss, fr;
        bit [32:0] r;
        bit was_full;
        was_full = model_full();
        nx = m;
        e_op = 6'd0; e_v1 = 32'd0; e_v2 = 32'd0; e_imm = 32'd0; e_pc = 32'd0; e_rob = 4'd0;
        if (clear) begin
            for (int i = 0; i < 16; i++) nx[i].busy = 1'b0;
            m = nx;
            return;
        end
        iss = -1; fr = -1;
        for (int i = 0; i < 16; i++) begin
            if (iss < 0 && m[i].busy && !m[i].p1 && !m[i].p2) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                r = snoop(m[i].p1, m[i].t1, m[i].v1); nx[i].p1 = r[32]; nx[i].v1 = r[31:0];
                r = snoop(m[i].p2, m[i].t2, m[i].v2); nx[i].p2 = r[32]; nx[i].v2 = r[31:0];
            end
        end
        if (iss >= 0) begin
            e_op = m[iss].op; e_v1 = m[iss].v1; e_v2 = m[iss].v2;
            e_imm = m[iss].imm; e_pc = m[iss].pc; e_rob = m[iss].rob;
            nx[iss].busy = 1'b0;
        end
        if (dispatch_valid && !was_full && fr >= 0) begin
            nx[fr].busy = 1'b1; nx[fr].op = dispatch_opnum;
            nx[fr].t1 = dispatch_q1; nx[fr].t2 = dispatch_q2;
            nx[fr].imm = dispatch_imm; nx[fr].pc = dispatch_pc; nx[fr].rob = dispatch_rob_id;
            r = snoop(dispatch_q1_pending, dispatch_q1, dispatch_v1); nx[fr].p1 = r[32]; nx[fr].v1 = r[31:0];
            r = snoop(dispatch_q2_pending, dispatch_q2, dispatch_v2); nx[fr].p2 = r[32]; nx[fr].v2 = r[31:0];
        end
        m = nx;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        clear = 1'b0; dispatch_valid = 1'b0; dispatch_opnum = 6'd0;
        dispatch_q1_pending = 1'b0; dispatch_q2_pending = 1'b0;
        dispatch_q1 = 4'd0; dispatch_q2 = 4'd0;
        dispatch_v1 = 32'd0; dispatch_v2 = 32'd0; dispatch_imm = 32'd0; dispatch_pc = 32'd0;
        dispatch_rob_id = 4'd0;
        alu_valid = 1'b0; alu_rob_id = 4'd0; alu_data = 32'd0;
        lsb_valid = 1'b0; lsb_rob_id = 4'd0; lsb_data = 32'd0;
    endtask

    task automatic set_dispatch(input bit [5:0] op, input bit p1, input bit [3:0] t1, input bit [31:0] v1,
                                input bit p2, input bit [3:0] t2, input bit [31:0] v2,
                                input bit [31:0] imm, input bit [31:0] pc, input bit [3:0] rob);
        dispatch_valid = 1'b1; dispatch_opnum = op;
        dispatch_q1_pending = p1; dispatch_q1 = t1; dispatch_v1 = v1;
        dispatch_q2_pending = p2; dispatch_q2 = t2; dispatch_v2 = v2;
        dispatch_imm = imm; dispatch_pc = pc; dispatch_rob_id = rob;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (opnum_to_ex !== 6'd0 || v1_to_ex !== 32'd0 || v2_to_ex !== 32'd0 ||
            imm_to_ex !== 32'd0 || pc_to_ex !== 32'd0 || rob_id_to_ex !== 4'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: op=%0d v1=%0h v2=%0h full=%0b required all zero", opnum_to_ex, v1_to_ex, v2_to_ex, full);
        end
    endtask

    task automatic test_add_ready();
        do_reset();
        set_dispatch(6'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 32'd0, 32'h100, 4'd3);
        tick();
        set_idle();
        checks++;
        if (opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL add_latency: op=%0d required 0 right after dispatch edge", opnum_to_ex);
        end
        tick();
        checks++;
        if (opnum_to_ex !== 6'd1 || v1_to_ex !== 32'd5 || v2_to_ex !== 32'd7 || rob_id_to_ex !== 4'd3 || pc_to_ex !== 32'h100) begin
            errors++;
            $display("FAIL add_issue: op=%0d v1=%0d v2=%0d rob=%0d pc=%0h required 1 5 7 3 100",
                     opnum_to_ex, v1_to_ex, v2_to_ex, rob_id_to_ex, pc_to_ex);
        end
        tick();
        checks++;
        if (opnum_to_ex !== 6'd0 || v1_to_ex !== 32'd0) begin
            errors++; $display("FAIL add_one_cycle: op=%0d v1=%0d required 0 0", opnum_to_ex, v1_to_ex);
        end
    endtask

    task automatic test_alu_wakeup();
        do_reset();
        set_dispatch(6'd2, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'd0, 32'd0, 32'd4, 32'h200, 4'd6);
        tick();
        set_idle();
        tick();
        checks++;
        if (opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL addi_wait: op=%0d required 0 while pending", opnum_to_ex);
        end
        alu_valid = 1'b1; alu_rob_id = 4'd2; alu_data = 32'h10;
        tick();
        set_idle();
        checks++;
        if (opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL addi_wake_edge: op=%0d required 0 at wakeup edge", opnum_to_ex);
        end
        tick();
        checks++;
        if (opnum_to_ex !== 6'd2 || v1_to_ex !== 32'h10 || imm_to_ex !== 32'd4 || rob_id_to_ex !== 4'd6) begin
            errors++;
            $display("FAIL addi_issue: op=%0d v1=%0h imm=%0d rob=%0d required 2 10 4 6",
                     opnum_to_ex, v1_to_ex, imm_to_ex, rob_id_to_ex);
        end
    endtask

    task automatic test_lsb_bypass();
        do_reset();
        set_dispatch(6'd3, 1'b0, 4'd0, 32'd9, 1'b1, 4'd5, 32'd0, 32'd0, 32'h300, 4'd1);
        lsb_valid = 1'b1; lsb_rob_id = 4'd5; lsb_data = 32'hAB;
        tick();
        set_idle();
        tick();
        checks++;
        if (opnum_to_ex !== 6'd3 || v2_to_ex !== 32'hAB || v1_to_ex !== 32'd9) begin
            errors++;
            $display("FAIL lsb_bypass: op=%0d v1=%0h v2=%0h required 3 9 ab", opnum_to_ex, v1_to_ex, v2_to_ex);
        end
    endtask

    task automatic test_fill_and_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_dispatch(6'd4, 1'b1, 4'd9, 32'hFFFF, 1'b0, 4'd0, 32'd100 + 32'(i), 32'd0, 32'(i * 4), 4'(i));
            tick();
        end
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL fill_full: full=%0b required 1", full);
        end
        set_dispatch(6'd5, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 32'd0, 32'd0, 4'd15);
        tick();
        set_idle();
        alu_valid = 1'b1; alu_rob_id = 4'd9; alu_data = 32'd1;
        lsb_valid = 1'b1; lsb_rob_id = 4'd9; lsb_data = 32'd2;
        tick();
        set_idle();
        checks++;
        if (full !== 1'b1 || opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL fill_wake: full=%0b op=%0d required 1 0", full, opnum_to_ex);
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (opnum_to_ex !== 6'd4 || v1_to_ex !== 32'd1 || v2_to_ex !== 32'd100 + 32'(k) || rob_id_to_ex !== 4'(k)) begin
                errors++;
                $display("FAIL drain_%0d: op=%0d v1=%0d v2=%0d rob=%0d required 4 1 %0d %0d",
                         k, opnum_to_ex, v1_to_ex, v2_to_ex, rob_id_to_ex, 100 + k, k);
            end
            if (k == 0) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++; $display("FAIL full_drop: full=%0b required 0", full);
                end
            end
        end
        tick();
        checks++;
        if (opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL dropped_17th: op=%0d required 0", opnum_to_ex);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_dispatch(6'd7, 1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd11, 32'd0, 32'd0, 4'd1);
        tick();
        set_dispatch(6'd8, 1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd22, 32'd0, 32'd0, 4'd2);
        tick();
        set_idle();
        alu_valid = 1'b1; alu_rob_id = 4'd4; alu_data = 32'h55;
        tick();
        set_idle();
        tick();
        checks++;
        if (opnum_to_ex !== 6'd7 || rob_id_to_ex !== 4'd1 || v1_to_ex !== 32'h55) begin
            errors++; $display("FAIL prio_first: op=%0d rob=%0d v1=%0h required 7 1 55", opnum_to_ex, rob_id_to_ex, v1_to_ex);
        end
        tick();
        checks++;
        if (opnum_to_ex !== 6'd8 || rob_id_to_ex !== 4'd2 || v2_to_ex !== 32'd22) begin
            errors++; $display("FAIL prio_second: op=%0d rob=%0d v2=%0d required 8 2 22", opnum_to_ex, rob_id_to_ex, v2_to_ex);
        end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_dispatch(6'd9, 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 4'(i));
            tick();
        end
        set_dispatch(6'd10, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 32'd0, 4'd5);
        clear = 1'b1;
        tick();
        set_idle();
        checks++;
        if (opnum_to_ex !== 6'd0 || full !== 1'b0) begin
            errors++; $display("FAIL clear_out: op=%0d full=%0b required 0 0", opnum_to_ex, full);
        end
        alu_valid = 1'b1; alu_rob_id = 4'd7; alu_data = 32'd3;
        tick();
        set_idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (opnum_to_ex !== 6'd0) begin
                errors++; $display("FAIL clear_no_issue_%0d: op=%0d required 0", k, opnum_to_ex);
            end
        end
        // async reset mid-cycle while a bundle is on the outputs and an entry is buffered
        set_dispatch(6'd11, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 32'd0, 32'd0, 4'd8);
        tick();
        set_dispatch(6'd12, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 32'd0, 32'd0, 4'd9);
        tick();
        set_idle();
        checks++;
        if (opnum_to_ex !== 6'd11) begin
            errors++; $display("FAIL pre_reset_issue: op=%0d required 11", opnum_to_ex);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (opnum_to_ex !== 6'd0 || v1_to_ex !== 32'd0 || v2_to_ex !== 32'd0 || rob_id_to_ex !== 4'd0 || full !== 1'b0) begin
            errors++; $display("FAIL async_reset: op=%0d v1=%0d rob=%0d full=%0b required all 0",
                               opnum_to_ex, v1_to_ex, rob_id_to_ex, full);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
        checks++;
        if (opnum_to_ex !== 6'd0) begin
            errors++; $display("FAIL reset_lost: op=%0d required 0", opnum_to_ex);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            set_idle();
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6) begin
                set_dispatch(6'($urandom_range(1, 63)),
                             1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom,
                             1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom,
                             $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 9) < 3) begin
                alu_valid = 1'b1; alu_rob_id = 4'($urandom_range(0, 5)); alu_data = $urandom;
            end
            if ($urandom_range(0, 9) < 3) begin
                lsb_valid = 1'b1; lsb_rob_id = 4'($urandom_range(0, 5)); lsb_data = $urandom;
            end
            checks++;
            if (full !== model_full()) begin
                errors++; $display("FAIL rand_full @%0d: full=%0b required %0b", n, full, model_full());
            end
            tick();
            checks++;
            if (opnum_to_ex !== e_op || v1_to_ex !== e_v1 || v2_to_ex !== e_v2 ||
                imm_to_ex !== e_imm || pc_to_ex !== e_pc || rob_id_to_ex !== e_rob) begin
                errors++;
                $display("FAIL rand_issue @%0d: op=%0d v1=%0h v2=%0h imm=%0h pc=%0h rob=%0d required %0d %0h %0h %0h %0h %0d",
                         n, opnum_to_ex, v1_to_ex, v2_to_ex, imm_to_ex, pc_to_ex, rob_id_to_ex,
                         e_op, e_v1, e_v2, e_imm, e_pc, e_rob);
            end
        end
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        test_reset();
        test_add_ready();
        test_alu_wakeup();
        test_lsb_bypass();
        test_fill_and_drain();
        test_priority();
        test_clear_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
